// File: rtl/branch_pkg.sv
// Shared types and constants for the branch predict unit: address modes,
// outcome encoding, 2-bit saturating counter type and its update helper.
package branch_pkg;

  localparam logic PC  = 1'b0;
  localparam logic RD  = 1'b1;
  localparam logic BT  = 1'b1;
  localparam logic BNT = 1'b0;

  typedef logic [1:0] ctr_t;

  localparam ctr_t SNT = 2'b00;
  localparam ctr_t WNT = 2'b01;
  localparam ctr_t WT  = 2'b10;
  localparam ctr_t ST  = 2'b11;

  // Saturating up/down step of a direction counter.
  function automatic ctr_t ctr_next(input ctr_t ctr, input logic taken);
    ctr_t result;
    result = ctr;
    if (taken == BT) begin
      if (ctr != ST) result = ctr + 2'd1;
    end else begin
      if (ctr != SNT) result = ctr - 2'd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/branch_predict_unit_if.sv
// Fetch/execute bus of the branch predict unit.
// BPU_PERF_EN adds the perf_branches / perf_mispredicts counters.
interface branch_predict_unit_if #(
  parameter int unsigned WordSize = 32
);
  logic                fetch_valid;
  logic [WordSize-1:0] fetch_pc;
  logic                pred_valid;
  logic                pred_taken;
  logic [WordSize-1:0] pred_target;
  logic                resolve_valid;
  logic [WordSize-1:0] resolve_pc;
  logic                addr_mode;
  logic                branch_taken;
  logic [WordSize-1:0] imm;
  logic [WordSize-1:0] rs1d;
  logic                pred_taken_in;
  logic [WordSize-1:0] pred_target_in;
  logic [WordSize-1:0] branch_addr;
  logic [WordSize-1:0] npc;
  logic                redirect;
  logic [WordSize-1:0] redirect_pc;
`ifdef BPU_PERF_EN
  logic [31:0]         perf_branches;
  logic [31:0]         perf_mispredicts;
`endif

  modport master (
    output fetch_valid, fetch_pc, resolve_valid, resolve_pc, addr_mode,
           branch_taken, imm, rs1d, pred_taken_in, pred_target_in,
    input  pred_valid, pred_taken, pred_target, branch_addr, npc,
           redirect, redirect_pc
`ifdef BPU_PERF_EN
    , input perf_branches, perf_mispredicts
`endif
  );

  modport slave (
    input  fetch_valid, fetch_pc, resolve_valid, resolve_pc, addr_mode,
           branch_taken, imm, rs1d, pred_taken_in, pred_target_in,
    output pred_valid, pred_taken, pred_target, branch_addr, npc,
           redirect, redirect_pc
`ifdef BPU_PERF_EN
    , output perf_branches, perf_mispredicts
`endif
  );

endinterface

// File: rtl/branch_addr_unit.sv
// Combinational resolve logic: branch target, correct next PC and
// mispredict detection for the instruction in execute.
module branch_addr_unit
  import branch_pkg::*;
#(
  parameter int unsigned WordSize  = 32,
  parameter int unsigned InstBytes = 4
) (
  input  logic                resolve_valid,
  input  logic [WordSize-1:0] resolve_pc,
  input  logic                addr_mode,
  input  logic                branch_taken,
  input  logic [WordSize-1:0] imm,
  input  logic [WordSize-1:0] rs1d,
  input  logic                pred_taken_in,
  input  logic [WordSize-1:0] pred_target_in,
  output logic [WordSize-1:0] branch_addr,
  output logic [WordSize-1:0] npc,
  output logic                mispredict_c
);

  logic [WordSize-1:0] sum;

  always_comb begin
    sum         = '0;
    branch_addr = '0;
    npc         = '0;
    if (addr_mode == RD) begin
      sum         = rs1d + imm;
      branch_addr = {sum[WordSize-1:1], 1'b0};
    end else begin
      sum         = resolve_pc + imm;
      branch_addr = sum;
    end
    npc = (branch_taken == BT) ? branch_addr : resolve_pc + WordSize'(InstBytes);
    mispredict_c = resolve_valid &&
                   ((pred_taken_in != branch_taken) ||
                    ((branch_taken == BT) && (pred_target_in != branch_addr)));
  end

endmodule

// File: rtl/branch_predict_unit.sv
// Branch predict unit: direct-mapped BTB with 2-bit counters, registered
// fetch prediction, execute-stage resolve and registered redirect.
// BPU_PERF_EN adds saturating branch / mispredict counters.
module branch_predict_unit
  import branch_pkg::*;
#(
  parameter int unsigned WordSize   = 32,
  parameter int unsigned NumEntries = 16,
  parameter int unsigned InstBytes  = 4
) (
  input logic                  clk,
  input logic                  rst,
  branch_predict_unit_if.slave bus
);

  localparam int unsigned IndexBits = $clog2(NumEntries);
  localparam int unsigned TagBits   = WordSize - IndexBits - 2;

  typedef struct packed {
    logic                valid;
    logic [TagBits-1:0]  tag;
    logic [WordSize-1:0] target;
    ctr_t                ctr;
  } btb_entry_t;

  btb_entry_t btb [NumEntries];

  logic [IndexBits-1:0] fetch_idx;
  logic [IndexBits-1:0] res_idx;
  logic [TagBits-1:0]   fetch_tag;
  logic [TagBits-1:0]   res_tag;
  btb_entry_t           fetch_entry;
  btb_entry_t           res_entry;
  logic                 fetch_hit;
  logic                 res_hit;
  logic                 fetch_taken;
  logic                 mispredict_c;

  assign fetch_idx   = bus.fetch_pc[IndexBits+1:2];
  assign fetch_tag   = bus.fetch_pc[WordSize-1:IndexBits+2];
  assign res_idx     = bus.resolve_pc[IndexBits+1:2];
  assign res_tag     = bus.resolve_pc[WordSize-1:IndexBits+2];
  assign fetch_entry = btb[fetch_idx];
  assign res_entry   = btb[res_idx];
  assign fetch_hit   = fetch_entry.valid && (fetch_entry.tag == fetch_tag);
  assign res_hit     = res_entry.valid && (res_entry.tag == res_tag);
  assign fetch_taken = fetch_hit && fetch_entry.ctr[1];

  branch_addr_unit #(
    .WordSize (WordSize),
    .InstBytes(InstBytes)
  ) u_addr (
    .resolve_valid (bus.resolve_valid),
    .resolve_pc    (bus.resolve_pc),
    .addr_mode     (bus.addr_mode),
    .branch_taken  (bus.branch_taken),
    .imm           (bus.imm),
    .rs1d          (bus.rs1d),
    .pred_taken_in (bus.pred_taken_in),
    .pred_target_in(bus.pred_target_in),
    .branch_addr   (bus.branch_addr),
    .npc           (bus.npc),
    .mispredict_c  (mispredict_c)
  );

  // Prediction/redirect registers and table training; lookup reads
  // pre-update contents because both happen on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NumEntries); i++) begin
        btb[i].valid <= 1'b0;
        btb[i].ctr   <= WNT;
      end
      bus.pred_valid  <= 1'b0;
      bus.pred_taken  <= 1'b0;
      bus.pred_target <= '0;
      bus.redirect    <= 1'b0;
      bus.redirect_pc <= '0;
    end else begin
      bus.pred_valid  <= bus.fetch_valid;
      bus.pred_taken  <= bus.fetch_valid && fetch_taken;
      bus.pred_target <= (bus.fetch_valid && fetch_taken) ? fetch_entry.target : '0;
      bus.redirect    <= mispredict_c;
      bus.redirect_pc <= mispredict_c ? bus.npc : '0;
      if (bus.resolve_valid) begin
        if (res_hit) begin
          btb[res_idx].ctr <= ctr_next(res_entry.ctr, bus.branch_taken);
          if (bus.branch_taken == BT) btb[res_idx].target <= bus.branch_addr;
        end else if (bus.branch_taken == BT) begin
          btb[res_idx].valid  <= 1'b1;
          btb[res_idx].tag    <= res_tag;
          btb[res_idx].target <= bus.branch_addr;
          btb[res_idx].ctr    <= WT;
        end
      end
    end
  end

`ifdef BPU_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.perf_branches    <= '0;
      bus.perf_mispredicts <= '0;
    end else begin
      if (bus.resolve_valid && (bus.perf_branches != '1))
        bus.perf_branches <= bus.perf_branches + 32'd1;
      if (mispredict_c && (bus.perf_mispredicts != '1))
        bus.perf_mispredicts <= bus.perf_mispredicts + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed bench for branch_predict_unit: resolve arithmetic vectors plus
// hand-written training, aliasing, bypass and reset sequences.
module tb_branch_predict_unit;
  import branch_pkg::*;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  branch_predict_unit_if #(.WordSize(32)) bus ();

  branch_predict_unit #(
    .WordSize  (32),
    .NumEntries(16),
    .InstBytes (4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rv;
    logic [31:0] pc;
    logic        mode;
    logic        taken;
    logic [31:0] imm;
    logic [31:0] rs1d;
    logic        pti;
    logic [31:0] ptgt;
    logic [31:0] e_baddr;
    logic [31:0] e_npc;
    logic        e_redir;
    logic [31:0] e_rpc;
  } vec_t;

  vec_t vecs [8];

  function automatic vec_t mk(input logic rv, input logic [31:0] pc, input logic mode,
                              input logic taken, input logic [31:0] imm, input logic [31:0] rs1d,
                              input logic pti, input logic [31:0] ptgt, input logic [31:0] e_baddr,
                              input logic [31:0] e_npc, input logic e_redir, input logic [31:0] e_rpc);
    vec_t v;
    v.rv = rv; v.pc = pc; v.mode = mode; v.taken = taken; v.imm = imm; v.rs1d = rs1d;
    v.pti = pti; v.ptgt = ptgt; v.e_baddr = e_baddr; v.e_npc = e_npc;
    v.e_redir = e_redir; v.e_rpc = e_rpc;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.fetch_valid    = 1'b0;
    bus.fetch_pc       = '0;
    bus.resolve_valid  = 1'b0;
    bus.resolve_pc     = '0;
    bus.addr_mode      = PC;
    bus.branch_taken   = BNT;
    bus.imm            = '0;
    bus.rs1d           = '0;
    bus.pred_taken_in  = 1'b0;
    bus.pred_target_in = '0;
  endtask

  task automatic drive_resolve(input logic [31:0] pc, input logic mode, input logic taken,
                               input logic [31:0] imm, input logic [31:0] rs1d,
                               input logic pti, input logic [31:0] ptgt);
    bus.resolve_valid  = 1'b1;
    bus.resolve_pc     = pc;
    bus.addr_mode      = mode;
    bus.branch_taken   = taken;
    bus.imm            = imm;
    bus.rs1d           = rs1d;
    bus.pred_taken_in  = pti;
    bus.pred_target_in = ptgt;
  endtask

  task automatic do_resolve(input logic [31:0] pc, input logic taken,
                            input logic pti, input logic [31:0] ptgt);
    drive_resolve(pc, PC, taken, 32'h40, 32'h0, pti, ptgt);
    step();
    bus.resolve_valid = 1'b0;
  endtask

  task automatic do_fetch(input logic [31:0] pc);
    bus.fetch_valid = 1'b1;
    bus.fetch_pc    = pc;
    step();
    bus.fetch_valid = 1'b0;
  endtask

  task automatic check_pred(input string name, input logic v, input logic t, input logic [31:0] tgt);
    check({name, ".pred_valid"},  32'(bus.pred_valid), 32'(v));
    check({name, ".pred_taken"},  32'(bus.pred_taken), 32'(t));
    check({name, ".pred_target"}, bus.pred_target, tgt);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    idle();
    rst = 1'b1;
    step();
    step();
    check_pred("reset", 1'b0, 1'b0, 32'h0);
    check("reset.redirect",    32'(bus.redirect), 32'h0);
    check("reset.redirect_pc", bus.redirect_pc,   32'h0);
    rst = 1'b0;

    vecs[0] = mk(1, 32'h100,      PC, BT,  32'h40,       32'h0,    0, 32'h0,   32'h140,   32'h140,   1, 32'h140);
    vecs[1] = mk(1, 32'h2000,     RD, BT,  32'h10,       32'h2001, 1, 32'h2000, 32'h2010, 32'h2010,  1, 32'h2010);
    vecs[2] = mk(1, 32'hFFFFFFF8, PC, BT,  32'h10,       32'h0,    1, 32'h8,   32'h8,     32'h8,     0, 32'h0);
    vecs[3] = mk(1, 32'h200,      PC, BNT, 32'h20,       32'h0,    0, 32'h0,   32'h220,   32'h204,   0, 32'h0);
    vecs[4] = mk(1, 32'h300,      PC, BNT, 32'hFFFFFFF0, 32'h0,    1, 32'h2F0, 32'h2F0,   32'h304,   1, 32'h304);
    vecs[5] = mk(0, 32'h400,      PC, BT,  32'h8,        32'h0,    0, 32'h0,   32'h408,   32'h408,   0, 32'h0);
    vecs[6] = mk(1, 32'h800,      RD, BT,  32'hFFFFFFFF, 32'h1000, 1, 32'hFFE, 32'hFFE,   32'hFFE,   0, 32'h0);
    vecs[7] = mk(1, 32'h600,      PC, BT,  32'h100,      32'h0,    1, 32'h704, 32'h700,   32'h700,   1, 32'h700);

    for (int i = 0; i < 8; i++) begin
      drive_resolve(vecs[i].pc, vecs[i].mode, vecs[i].taken, vecs[i].imm, vecs[i].rs1d,
                    vecs[i].pti, vecs[i].ptgt);
      bus.resolve_valid = vecs[i].rv;
      #1;
      check($sformatf("vec%0d.branch_addr", i), bus.branch_addr, vecs[i].e_baddr);
      check($sformatf("vec%0d.npc", i),         bus.npc,         vecs[i].e_npc);
      step();
      bus.resolve_valid = 1'b0;
      check($sformatf("vec%0d.redirect", i),    32'(bus.redirect), 32'(vecs[i].e_redir));
      check($sformatf("vec%0d.redirect_pc", i), bus.redirect_pc,   vecs[i].e_rpc);
    end

    // Clean table for the training sequences.
    rst = 1'b1;
    step();
    rst = 1'b0;

    do_fetch(32'h100);
    check_pred("cold", 1'b1, 1'b0, 32'h0);
    check("cold.redirect", 32'(bus.redirect), 32'h0);

    drive_resolve(32'h100, PC, BT, 32'h40, 32'h0, 1'b0, 32'h0);
    #1;
    check("alloc.branch_addr", bus.branch_addr, 32'h140);
    check("alloc.npc",         bus.npc,         32'h140);
    step();
    bus.resolve_valid = 1'b0;
    check("alloc.redirect",    32'(bus.redirect), 32'h1);
    check("alloc.redirect_pc", bus.redirect_pc,   32'h140);

    do_fetch(32'h100);
    check_pred("trained", 1'b1, 1'b1, 32'h140);
    check("pulse.redirect", 32'(bus.redirect), 32'h0);

    // 10 -> 01 with a mispredict, then 01 -> 00.
    do_resolve(32'h100, BNT, 1'b1, 32'h140);
    check("nt1.redirect",    32'(bus.redirect), 32'h1);
    check("nt1.redirect_pc", bus.redirect_pc,   32'h104);
    do_resolve(32'h100, BNT, 1'b0, 32'h0);
    check("nt2.redirect", 32'(bus.redirect), 32'h0);
    do_fetch(32'h100);
    check_pred("snt", 1'b1, 1'b0, 32'h0);

    // 00 -> 01, then a lookup alongside the 01 -> 10 update sees 01.
    do_resolve(32'h100, BT, 1'b0, 32'h0);
    bus.fetch_valid = 1'b1;
    bus.fetch_pc    = 32'h100;
    drive_resolve(32'h100, PC, BT, 32'h40, 32'h0, 1'b0, 32'h0);
    step();
    idle();
    check_pred("nobypass", 1'b1, 1'b0, 32'h0);
    do_fetch(32'h100);
    check_pred("after_bypass", 1'b1, 1'b1, 32'h140);

    // Saturate at 11, one not-taken leaves it predicting taken.
    do_resolve(32'h100, BT, 1'b1, 32'h140);
    do_resolve(32'h100, BT, 1'b1, 32'h140);
    do_resolve(32'h100, BNT, 1'b1, 32'h140);
    do_fetch(32'h100);
    check_pred("saturate", 1'b1, 1'b1, 32'h140);

    step();
    check_pred("no_fetch", 1'b0, 1'b0, 32'h0);

    // 0x500 shares index 0 with 0x100 but has a different tag.
    do_resolve(32'h500, BT, 1'b0, 32'h0);
    do_fetch(32'h100);
    check_pred("alias_old", 1'b1, 1'b0, 32'h0);
    do_fetch(32'h500);
    check_pred("alias_new", 1'b1, 1'b1, 32'h540);

    // Reset wins over a simultaneous fetch and a mispredicting resolve.
    rst             = 1'b1;
    bus.fetch_valid = 1'b1;
    bus.fetch_pc    = 32'h500;
    drive_resolve(32'h700, PC, BT, 32'h40, 32'h0, 1'b0, 32'h0);
    step();
    rst = 1'b0;
    idle();
    check_pred("rst_busy", 1'b0, 1'b0, 32'h0);
    check("rst_busy.redirect",    32'(bus.redirect), 32'h0);
    check("rst_busy.redirect_pc", bus.redirect_pc,   32'h0);
    do_fetch(32'h500);
    check_pred("cleared_500", 1'b1, 1'b0, 32'h0);
    do_fetch(32'h700);
    check_pred("dropped_700", 1'b1, 1'b0, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
